// File: rtl/nbody_hls_deadlock_report_ctrl.sv
// Deadlock report controller for the n-body HLS dataflow: debounces detection, injects an origin token,
// traces the token around the process ring and presents a one-shot report to a consumer.
module nbody_hls_deadlock_report_ctrl #(
   parameter int PROC_NUM  = 4,
   parameter int PROC_ID_W = 2,
   parameter int DEBOUNCE  = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [PROC_NUM-1:0]  dl_detect_vec,
   input  logic [PROC_NUM-1:0]  proc_token_vec,
   input  logic                 report_ack,
   output logic                 dl_detect_in,
   output logic [PROC_NUM-1:0]  origin_vec,
   output logic                 token_clear,
   output logic                 dl_report_vld,
   output logic [PROC_ID_W-1:0] dl_report_id,
   output logic [PROC_NUM-1:0]  dl_report_path,
   output logic [15:0]          dl_report_cycles,
   output logic                 dl_report_timeout
);

   typedef enum logic [2:0] {IDLE, FILTER, ORIGIN, TRACE, REPORT} state_t;

   localparam logic [15:0]         DEBOUNCE_W = 16'(DEBOUNCE);
   localparam logic [15:0]         TIMEOUT_W  = 16'(TIMEOUT);
   localparam logic [PROC_NUM-1:0] ONE_HOT0   = PROC_NUM'(1);

   state_t               state, state_next;
   logic [15:0]          cnt, cnt_next, cnt_inc;
   logic [PROC_ID_W-1:0] id, id_next, lowest_id;
   logic [PROC_NUM-1:0]  path, path_next;
   logic [15:0]          cycles_next;
   logic                 timeout_next;
   logic                 any_detect, origin_back;

   assign any_detect     = |dl_detect_vec;
   assign origin_back    = dl_detect_vec[id];
   assign cnt_inc        = cnt + 16'd1;
   assign token_clear    = (state == TRACE) && origin_back;
   assign dl_report_id   = id;
   assign dl_report_path = path;

   // Lowest-index detecting unit becomes the trace origin.
   always_comb begin
      lowest_id = '0;
      for (int i = PROC_NUM - 1; i >= 0; i--) begin
         if (dl_detect_vec[i]) lowest_id = PROC_ID_W'(i);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      id_next      = id;
      path_next    = path;
      cycles_next  = dl_report_cycles;
      timeout_next = dl_report_timeout;
      case (state)
         IDLE: begin
            if (any_detect) begin
               state_next = FILTER;
               cnt_next   = 16'd1;
            end else begin
               cnt_next   = '0;
            end
         end
         FILTER: begin
            if (!any_detect) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == DEBOUNCE_W) begin
               state_next = ORIGIN;
               id_next    = lowest_id;
            end else begin
               cnt_next   = cnt_inc;
            end
         end
         ORIGIN: begin
            state_next = TRACE;
            path_next  = ONE_HOT0 << id;
            cnt_next   = '0;
         end
         TRACE: begin
            // Token return wins over a timeout landing in the same cycle.
            path_next = path | proc_token_vec;
            cnt_next  = cnt_inc;
            if (origin_back) begin
               state_next   = REPORT;
               cycles_next  = cnt_inc;
               timeout_next = 1'b0;
            end else if (cnt_inc == TIMEOUT_W) begin
               state_next   = REPORT;
               cycles_next  = TIMEOUT_W;
               timeout_next = 1'b1;
            end
         end
         REPORT: begin
            if (report_ack) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered outputs follow the next state so they line up with the state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt               <= '0;
         id                <= '0;
         path              <= '0;
         dl_report_cycles  <= '0;
         dl_report_timeout <= 1'b0;
         dl_detect_in      <= 1'b0;
         origin_vec        <= '0;
         dl_report_vld     <= 1'b0;
      end else begin
         cnt               <= cnt_next;
         id                <= id_next;
         path              <= path_next;
         dl_report_cycles  <= cycles_next;
         dl_report_timeout <= timeout_next;
         dl_detect_in      <= (state_next == ORIGIN) || (state_next == TRACE) || (state_next == REPORT);
         origin_vec        <= (state_next == ORIGIN) ? (ONE_HOT0 << id_next) : '0;
         dl_report_vld     <= (state_next == REPORT);
      end
   end

endmodule

// File: tb/tb_nbody_hls_deadlock_report_ctrl.sv
// Bench for nbody_hls_deadlock_report_ctrl: directed scenarios plus random bursts, checked every cycle
// against a behavioural model of the detect/trace/report protocol.
module tb_nbody_hls_deadlock_report_ctrl;

   localparam int PROC_NUM  = 4;
   localparam int PROC_ID_W = 2;
   localparam int DEBOUNCE  = 4;
   localparam int TIMEOUT   = 8;

   logic                 clock;
   logic                 reset;
   logic [PROC_NUM-1:0]  dl_detect_vec;
   logic [PROC_NUM-1:0]  proc_token_vec;
   logic                 report_ack;
   logic                 dl_detect_in;
   logic [PROC_NUM-1:0]  origin_vec;
   logic                 token_clear;
   logic                 dl_report_vld;
   logic [PROC_ID_W-1:0] dl_report_id;
   logic [PROC_NUM-1:0]  dl_report_path;
   logic [15:0]          dl_report_cycles;
   logic                 dl_report_timeout;

   int n_vec = 0;
   int n_err = 0;

   nbody_hls_deadlock_report_ctrl #(
      .PROC_NUM(PROC_NUM), .PROC_ID_W(PROC_ID_W), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock), .reset(reset),
      .dl_detect_vec(dl_detect_vec), .proc_token_vec(proc_token_vec), .report_ack(report_ack),
      .dl_detect_in(dl_detect_in), .origin_vec(origin_vec), .token_clear(token_clear),
      .dl_report_vld(dl_report_vld), .dl_report_id(dl_report_id), .dl_report_path(dl_report_path),
      .dl_report_cycles(dl_report_cycles), .dl_report_timeout(dl_report_timeout)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Behavioural model: run length of detection, then origin, trace length and visited set.
   int                  run_len;
   bit                  m_origin, m_trace, m_report;
   int                  oid;
   logic [PROC_NUM-1:0] visited;
   int                  tlen;
   int                  rep_cycles;
   bit                  rep_to;

   function automatic int lowestSet(input logic [PROC_NUM-1:0] v);
      for (int i = 0; i < PROC_NUM; i++) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         run_len <= 0; m_origin <= 0; m_trace <= 0; m_report <= 0;
         oid <= 0; visited <= '0; tlen <= 0; rep_cycles <= 0; rep_to <= 0;
      end else if (m_report) begin
         if (report_ack) m_report <= 0;
      end else if (m_trace) begin
         visited <= visited | proc_token_vec;
         tlen    <= tlen + 1;
         if (dl_detect_vec[oid]) begin
            m_trace <= 0; m_report <= 1; rep_cycles <= tlen + 1; rep_to <= 0;
         end else if (tlen + 1 == TIMEOUT) begin
            m_trace <= 0; m_report <= 1; rep_cycles <= TIMEOUT; rep_to <= 1;
         end
      end else if (m_origin) begin
         m_origin <= 0; m_trace <= 1; tlen <= 0;
         visited  <= PROC_NUM'(1) << oid;
      end else begin
         if (dl_detect_vec == '0) run_len <= 0;
         else if (run_len == DEBOUNCE) begin
            m_origin <= 1; oid <= lowestSet(dl_detect_vec); run_len <= 0;
         end else run_len <= run_len + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clock) begin
      checkOutput("dl_detect_in", 32'(dl_detect_in), 32'(m_origin | m_trace | m_report));
      checkOutput("origin_vec", 32'(origin_vec), m_origin ? 32'(PROC_NUM'(1) << oid) : 32'd0);
      checkOutput("token_clear", 32'(token_clear), 32'(m_trace && dl_detect_vec[oid]));
      checkOutput("dl_report_vld", 32'(dl_report_vld), 32'(m_report));
      if (m_report) begin
         checkOutput("dl_report_id", 32'(dl_report_id), 32'(oid));
         checkOutput("dl_report_path", 32'(dl_report_path), 32'(visited));
         checkOutput("dl_report_cycles", 32'(dl_report_cycles), 32'(rep_cycles));
         checkOutput("dl_report_timeout", 32'(dl_report_timeout), 32'(rep_to));
      end
   end

   // Drives inputs for one cycle and returns 1 time unit after the consuming edge.
   task automatic applyStimulus(input logic [PROC_NUM-1:0] v, input logic [PROC_NUM-1:0] t, input logic a);
      dl_detect_vec  = v;
      proc_token_vec = t;
      report_ack     = a;
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [PROC_NUM-1:0] v, t;
      int                  len, total;

      reset = 1'b0; dl_detect_vec = '0; proc_token_vec = '0; report_ack = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset dl_detect_in", 32'(dl_detect_in), 32'd0);
      checkOutput("reset origin_vec", 32'(origin_vec), 32'd0);
      checkOutput("reset dl_report_vld", 32'(dl_report_vld), 32'd0);
      checkOutput("reset dl_report_cycles", 32'(dl_report_cycles), 32'd0);
      checkOutput("reset dl_report_timeout", 32'(dl_report_timeout), 32'd0);
      reset = 1'b1;
      applyStimulus(4'b0000, 4'b0000, 1'b0);

      // Debounce to origin, then a three-cycle token loop through units 2, 3, 1.
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(4'b0110, 4'b0000, 1'b0);
         if (k == 4) checkOutput("filter origin_vec", 32'(origin_vec), 32'd0);
      end
      checkOutput("origin origin_vec", 32'(origin_vec), 32'b0010);
      checkOutput("origin dl_detect_in", 32'(dl_detect_in), 32'd1);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      checkOutput("trace origin_vec", 32'(origin_vec), 32'd0);
      applyStimulus(4'b0000, 4'b0100, 1'b0);
      applyStimulus(4'b0000, 4'b1000, 1'b0);
      dl_detect_vec = 4'b0010; proc_token_vec = 4'b0010;
      #1 checkOutput("return token_clear", 32'(token_clear), 32'd1);
      applyStimulus(4'b0010, 4'b0010, 1'b0);
      for (int k = 0; k < 10; k++) begin
         checkOutput("hold vld", 32'(dl_report_vld), 32'd1);
         checkOutput("hold path", 32'(dl_report_path), 32'b1110);
         checkOutput("hold cycles", 32'(dl_report_cycles), 32'd3);
         checkOutput("hold timeout", 32'(dl_report_timeout), 32'd0);
         checkOutput("hold id", 32'(dl_report_id), 32'd1);
         applyStimulus(4'($urandom), 4'($urandom), 1'b0);
      end
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("ack vld", 32'(dl_report_vld), 32'd0);
      checkOutput("ack dl_detect_in", 32'(dl_detect_in), 32'd0);

      // Short glitch must not start a trace.
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(4'b0000, 4'b0000, 1'b0);
         checkOutput("glitch origin_vec", 32'(origin_vec), 32'd0);
         checkOutput("glitch dl_detect_in", 32'(dl_detect_in), 32'd0);
      end

      // Timeout: origin unit 3 never sees the token back; other units detecting are ignored.
      repeat (5) applyStimulus(4'b1000, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      for (int k = 1; k <= TIMEOUT; k++) begin
         v = 4'($urandom) & 4'b0111;
         t = 4'($urandom);
         dl_detect_vec = v;
         #1 checkOutput("timeout token_clear", 32'(token_clear), 32'd0);
         applyStimulus(v, t, 1'b0);
         if (k == TIMEOUT - 1) checkOutput("pre-timeout vld", 32'(dl_report_vld), 32'd0);
      end
      checkOutput("timeout vld", 32'(dl_report_vld), 32'd1);
      checkOutput("timeout flag", 32'(dl_report_timeout), 32'd1);
      checkOutput("timeout cycles", 32'(dl_report_cycles), 32'd8);
      applyStimulus(4'b0000, 4'b0000, 1'b1);

      // Token return on the final allowed cycle beats the timeout.
      repeat (5) applyStimulus(4'b0101, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      repeat (TIMEOUT - 1) applyStimulus(4'($urandom) & 4'b1110, 4'($urandom), 1'b0);
      dl_detect_vec = 4'b0001;
      #1 checkOutput("tie token_clear", 32'(token_clear), 32'd1);
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("tie timeout", 32'(dl_report_timeout), 32'd0);
      checkOutput("tie cycles", 32'(dl_report_cycles), 32'd8);
      applyStimulus(4'b0000, 4'b0000, 1'b1);

      // Asynchronous reset in the middle of a trace, then a fresh detection.
      repeat (5) applyStimulus(4'b0100, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0000, 4'b0001, 1'b0);
      applyStimulus(4'b0000, 4'b0010, 1'b0);
      dl_detect_vec = 4'b0100;
      #1 reset = 1'b0;
      #1;
      checkOutput("async dl_detect_in", 32'(dl_detect_in), 32'd0);
      checkOutput("async origin_vec", 32'(origin_vec), 32'd0);
      checkOutput("async token_clear", 32'(token_clear), 32'd0);
      checkOutput("async vld", 32'(dl_report_vld), 32'd0);
      checkOutput("async cycles", 32'(dl_report_cycles), 32'd0);
      @(posedge clock);
      #1;
      dl_detect_vec = 4'b0010;
      reset = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(4'b0010, 4'b0000, 1'b0);
         if (k == 1) checkOutput("restart dl_detect_in", 32'(dl_detect_in), 32'd0);
      end
      checkOutput("restart origin_vec", 32'(origin_vec), 32'b0010);
      applyStimulus(4'b0000, 4'b0000, 1'b0);
      applyStimulus(4'b0010, 4'b0000, 1'b0);
      checkOutput("one-cycle trace cycles", 32'(dl_report_cycles), 32'd1);
      checkOutput("one-cycle trace path", 32'(dl_report_path), 32'b0010);
      applyStimulus(4'b0000, 4'b0000, 1'b1);

      // Random bursts of held detection patterns with random tokens and acks.
      total = 0;
      while (total < 600) begin
         len = $urandom_range(1, 7);
         v   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
         for (int k = 0; k < len; k++) begin
            applyStimulus(v, 4'($urandom), ($urandom_range(0, 3) == 0));
            total++;
         end
      end
      repeat (20) applyStimulus(4'b0000, 4'b0000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
